// File: rtl/lane_deser_pkg.sv
// lane_deser_pkg
// Shared definitions for the three-lane serial deserializer:
//   LANES                  number of serial lanes packed per output word
//   WIDTH_MIN / WIDTH_MAX  legal range of the per-lane word width
//   buf_state_t            occupancy state of the two-entry output buffer
package lane_deser_pkg;

    localparam int LANES     = 3;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/lane_deser_shift.sv
// lane_deser_shift
// One serial lane: WIDTH-bit MSB-first shift register, plus a running
// even-parity bit when LANE_DESER_PARITY_EN is defined.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            sample strobe (in_valid)
//   din           serial bit for this lane
//   word_done     (parity build) this sample completes the word
//   par_next      (parity build) parity of the word including din
//   word_next     shift register contents including din
module lane_deser_shift
    import lane_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
`ifdef LANE_DESER_PARITY_EN
    input  logic             word_done,
    output logic             par_next,
`endif
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-1:0] sr;

    // Combinational view including the current bit, so the top can push the
    // completed word in the same cycle the last bit arrives.
    assign word_next = {sr[WIDTH-2:0], din};

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (en) begin
            sr <= word_next;
        end
    end

`ifdef LANE_DESER_PARITY_EN
    logic par;

    assign par_next = par ^ din;

    // Parity restarts at each word boundary; the completed value is taken
    // from par_next by the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (en) begin
            par <= word_done ? 1'b0 : par_next;
        end
    end
`endif

endmodule

// File: rtl/serial_lane_deserializer.sv
// serial_lane_deserializer
// Samples three serial lanes on in_valid, packs WIDTH bits per lane into one
// {lane2, lane1, lane0} word and offers it through a two-entry buffer on a
// valid/ready interface. A word completed while both entries are full and
// nothing is popped is dropped and sets sticky overflow.
// Optional feature macro: LANE_DESER_PARITY_EN adds out_parity (per-lane even
// parity) stored alongside each buffered word.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            sample enable
//   in1, in2, in3       lane 0/1/2 serial bits
//   out_data            head word, each lane MSB-first
//   out_valid           head word present
//   out_ready           consumer accepts head word
//   bit_cnt             bits collected toward the current word
//   overflow            sticky: a completed word was dropped
//   out_parity          (parity build) per-lane parity of head word
//
// Buffer FSM
//   state | meaning
//   EMPTY | no word held, out_valid low
//   ONE   | head holds a word
//   TWO   | head and spare both hold words; another push without pop drops
module serial_lane_deserializer
    import lane_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in1,
    input  logic                     in2,
    input  logic                     in3,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow
`ifdef LANE_DESER_PARITY_EN
    ,
    output logic [LANES-1:0]         out_parity
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = LANES * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef LANE_DESER_PARITY_EN
    localparam int EW = DW + LANES;
`else
    localparam int EW = DW;
`endif

    logic [LANES-1:0] lane_bit;
    logic [WIDTH-1:0] lane_word [LANES];
    logic [DW-1:0]    word_in;
    logic [EW-1:0]    entry_in;
    logic [EW-1:0]    head_q;
    logic [EW-1:0]    spare_q;
    logic             push;
    logic             pop;
    buf_state_t       state;

    assign lane_bit = {in3, in2, in1};
    assign push     = in_valid && (bit_cnt == CNT_LAST);
    assign pop      = out_valid && out_ready;

`ifdef LANE_DESER_PARITY_EN
    logic [LANES-1:0] par_in;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_deser_shift #(
            .WIDTH     (WIDTH)
        ) u_shift (
            .clk       (clk),
            .rst       (rst),
            .en        (in_valid),
            .din       (lane_bit[g]),
`ifdef LANE_DESER_PARITY_EN
            .word_done (push),
            .par_next  (par_in[g]),
`endif
            .word_next (lane_word[g])
        );

        assign word_in[g*WIDTH +: WIDTH] = lane_word[g];
    end

`ifdef LANE_DESER_PARITY_EN
    assign entry_in   = {par_in, word_in};
    assign out_parity = head_q[EW-1:DW];
`else
    assign entry_in   = word_in;
`endif

    assign out_data = head_q[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (in_valid) begin
            // Explicit wrap keeps non-power-of-two widths correct.
            bit_cnt <= push ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_q    <= '0;
            spare_q   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q    <= entry_in;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= entry_in;
                    end else if (push) begin
                        spare_q <= entry_in;
                        state   <= TWO;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q <= spare_q;
                        if (push) begin
                            spare_q <= entry_in;
                        end else begin
                            state <= ONE;
                        end
                    end else if (push) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_lane_deserializer.md
# serial_lane_deserializer

Three-lane serial-to-parallel capture stage placed directly downstream of the dual-register `clk`/reset test cores. It samples the three 1-bit result lanes (`out1`/`out2`/`out3` of the upstream core) on qualified cycles and packs each lane into a WIDTH-bit word. It presents one packed 3×WIDTH word per WIDTH samples on a valid/ready interface, through a two-entry output buffer with sticky overflow reporting.

## Interface
- `WIDTH`, 8: bits per lane per word; legal range 2..32.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  sample-enable; lanes are sampled only when high.
- `in1`  input  1  lane 0 serial bit.
- `in2`  input  1  lane 1 serial bit.
- `in3`  input  1  lane 2 serial bit.
- `out_data`  output  3*WIDTH  packed word `{lane2, lane1, lane0}`; each lane is MSB-first, so the first sampled bit is the lane MSB.
- `out_valid`  output  1  `out_data` holds a word.
- `out_ready`  input  1  consumer accepts the word when `out_valid && out_ready`.
- `bit_cnt`  output  $clog2(WIDTH)  bits collected toward the current word.
- `overflow`  output  1  sticky; a completed word was dropped.

## Operation
- **Shift:** on each cycle with `in_valid=1`, each lane register updates as `sr <= {sr[WIDTH-2:0], inN}` and `bit_cnt` increments.
- **Word completion:** the cycle in which `in_valid=1` and `bit_cnt==WIDTH-1`. In that cycle:
  - the packed word, including the current bit, is pushed into the buffer;
  - `bit_cnt` wraps to 0.
- **Buffer FSM:** `EMPTY`, `ONE`, `TWO`. `push` = word completion; `pop` = `out_valid && out_ready`.
  - From `EMPTY`: push → `ONE`.
  - From `ONE`: push without pop → `TWO`; pop without push → `EMPTY`; push and pop together → stay in `ONE`, with the new word in the head.
  - From `TWO`: pop → `ONE`, and the spare entry moves to the head; push and pop together → stay in `TWO`, no loss.
  - From `TWO`, push without pop → word dropped, `overflow` set to 1, state unchanged.
- **Output rules:**
  - `out_valid` = state ≠ `EMPTY`.
  - `out_data` = head entry. It holds stable while `out_valid && !out_ready`.
- **`overflow`:** cleared only by `rst`.
- **Reset:** `rst` aborts any partial word. Reset values:
  - `bit_cnt`=0, lane registers=0, state `EMPTY`;
  - `out_valid`=0, `out_data`=0, `overflow`=0.
- **Priority:** `rst` overrides all same-cycle events.

## Timing
- **Latency:** completion in cycle N → `out_valid`=1 and the word on `out_data` at cycle N+1 (registered, one cycle).
- **Throughput:** one word per WIDTH qualified samples. The buffer absorbs one word of consumer stall.
- `out_ready` has no combinational path to any output.
- `in_valid` gaps stretch words arbitrarily. `bit_cnt` holds during gaps.
- **Reset mid-operation:** all outputs show their reset values in the cycle after `rst` is sampled high. Sampling resumes on the first `in_valid` after `rst` falls.

## Configuration
- `LANE_DESER_PARITY_EN` defined:
  - adds output `out_parity`, 3 bits, one even-parity bit per lane (XOR of that lane's WIDTH bits);
  - the parity bits are stored in the buffer alongside each word, so they follow the same latency and hold rules;
  - reset value is 0.
- Undefined: the port and its storage are absent; behaviour is otherwise identical.

## Structure
- **Package `lane_deser_pkg`:**
  - buffer state enum (`EMPTY`/`ONE`/`TWO`);
  - `LANES`=3;
  - WIDTH legality bounds.
- **Sub-module `lane_deser_shift`:** one per lane. It holds the WIDTH-bit shift register and, when `LANE_DESER_PARITY_EN` is defined, a running parity bit. Instantiated three times.
- **Top level:** `bit_cnt`, the buffer FSM, and the packing.

## Test plan
All scenarios use WIDTH=8.
1. Reset, then 8 consecutive `in_valid` with in1=1,0,1,0,0,1,0,1 and in2=in3=0, `out_ready`=1 → `out_data`=0x0000A5 and `out_valid`=1 for exactly one cycle, one cycle after the 8th sample.
2. Same 8 samples with `in_valid` toggling every other cycle → same word, emitted one cycle after the 8th qualified sample; `bit_cnt` holds during gaps.
3. `out_ready`=0, push two words (0xFF from lane 2 = 0xFF0000, then 0x00FF00) → `out_valid` stays 1 with 0xFF0000 stable and `overflow`=0. A third word → `overflow`=1, and the first two words drain in order once `out_ready`=1.
4. In state `TWO`, word completion coincides with `out_ready`=1 → no overflow; the three words arrive in order.
5. `rst` asserted after 5 bits → next cycle `bit_cnt`=0 and `out_valid`=0. A following full 8-bit word is captured cleanly, with no residue from the aborted bits.
6. With `LANE_DESER_PARITY_EN` defined, lane0=0x07 and lane1=0x03 → `out_parity`=3'b001.
